fp_requant: RTL

FP_REQUANT -- requirements
Module: fp_requant

---
 rtl/fp_requant.sv | 98 +++++++++
 1 files changed

// File: rtl/fp_requant.sv
// Two-stage signed fixed-point requantizer: round or truncate to fewer fractional
// bits, then saturate into the narrower output format with valid/ready handshake.
module fp_requant #(
  parameter int IN_INT   = 8,
  parameter int IN_FRAC  = 5,
  parameter int OUT_INT  = 4,
  parameter int OUT_FRAC = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IN_INT+IN_FRAC-1:0]   in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        round_en,
  output logic [OUT_INT+OUT_FRAC-1:0] out_data,
  output logic                        out_sat,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [7:0]                  sat_count,
  input  logic                        sat_clr
);

  localparam int W_IN  = IN_INT + IN_FRAC;
  localparam int W_OUT = OUT_INT + OUT_FRAC;
  localparam int D     = IN_FRAC - OUT_FRAC;
  localparam int RSH   = (D > 0) ? D - 1 : 0;

  localparam logic signed [W_IN:0] ONE     = {{W_IN{1'b0}}, 1'b1};
  localparam logic signed [W_IN:0] RND_INC = (D > 0) ? (ONE <<< RSH) : '0;
  localparam logic signed [W_IN:0] SAT_MAX = (ONE <<< (W_OUT - 1)) - ONE;
  localparam logic signed [W_IN:0] SAT_MIN = -(ONE <<< (W_OUT - 1));

  logic                   stall;
  logic                   s1_valid;
  logic signed [W_IN:0]   s1_val;
  logic signed [W_IN:0]   in_ext;
  logic signed [W_IN:0]   s1_next;
  logic [W_OUT-1:0]       sat_data;
  logic                   sat_flag;
  logic                   out_xfer;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign out_xfer = out_valid && out_ready;

  // One extra headroom bit keeps the rounding increment from wrapping at the input maximum.
  always_comb begin
    in_ext = {in_data[W_IN-1], in_data};
    if (round_en) begin
      in_ext = in_ext + RND_INC;
    end
    s1_next = in_ext >>> D;
  end

  always_comb begin
    sat_data = s1_val[W_OUT-1:0];
    sat_flag = 1'b0;
    if (s1_val > SAT_MAX) begin
      sat_data = SAT_MAX[W_OUT-1:0];
      sat_flag = 1'b1;
    end else if (s1_val < SAT_MIN) begin
      sat_data = SAT_MIN[W_OUT-1:0];
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_val    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      if (in_valid) begin
        s1_val <= s1_next;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= sat_data;
        out_sat  <= sat_flag;
      end
    end
  end

  // Clear takes priority over a coincident saturated delivery.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (out_xfer && out_sat && (sat_count != 8'hFF)) begin
      sat_count <= sat_count + 8'd1;
    end
  end

endmodule
